inst_loader: RTL

- Sits directly downstream of the RS-232C receiver (i232c) inside top.
- In LOAD phase it assembles received bytes, MSB first, into 32-bit instruction words and writes them to instruction memory at consecutive addresses.
- The end-marker word 32'hFFFFFFFF ends loading. It asserts `done`, which releases the CPU.
- In RUN phase, every later received byte is forwarded to the CPU input port as program input data.

---
 rtl/inst_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: assembles received bytes (MSB first) into 32-bit instruction words,
// writes them to instruction memory, and after the end-marker forwards every later
// byte to the CPU input port.
// Optional build macro LOADER_TIMEOUT_EN: discards a partial word after TIMEOUT idle cycles.
module inst_loader #(
    parameter int          ADDR_WIDTH = 15,
    parameter logic [31:0] END_MARKER = 32'hFFFFFFFF,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  done,
    output logic                  overflow,
    output logic                  io_valid,
    output logic [7:0]            io_data,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    logic [0:0]            state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           shreg_q, shreg_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  iov_q, iov_d;
    logic [7:0]            iod_q, iod_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic [31:0]           word_w;
`ifdef LOADER_TIMEOUT_EN
    logic [15:0]           idle_q, idle_d;
`else
    // TIMEOUT has no role in this build; nothing is generated from it.
    if (TIMEOUT != 16'd0) begin : g_no_timeout
    end
`endif

    // Only the low 24 bits of history are needed: the 4th byte completes the word.
    assign word_w = {shreg_q, rx_data};

    // Next-state logic for byte assembly, memory writes and byte forwarding
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        iov_d   = 1'b0;
        iod_d   = iod_q;
        wc_d    = wc_q;
`ifdef LOADER_TIMEOUT_EN
        idle_d  = idle_q;
`endif

        // Address/count advance the cycle after the write pulse; address saturates
        // at the last word so it never wraps back onto word 0.
        if (we_q) begin
            wc_d = wc_q + 1'b1;
            if (addr_q != ADDR_LAST) begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (state_q == ST_LOAD) begin
            if (rx_valid) begin
                shreg_d = word_w[23:0];
                bcnt_d  = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    if (word_w == END_MARKER) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else if (!wc_q[ADDR_WIDTH]) begin
                        we_d    = 1'b1;
                        wdata_d = word_w;
                    end else begin
                        ovf_d   = 1'b1;
                    end
                end
            end
`ifdef LOADER_TIMEOUT_EN
            if (rx_valid || bcnt_q == 2'd0) begin
                idle_d = '0;
            end else if (idle_q == TIMEOUT) begin
                idle_d  = '0;
                bcnt_d  = '0;
                shreg_d = '0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
`endif
        end else begin
            if (rx_valid) begin
                iov_d = 1'b1;
                iod_d = rx_data;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= ST_LOAD;
            bcnt_q  <= '0;
            shreg_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            iov_q   <= 1'b0;
            iod_q   <= '0;
            wc_q    <= '0;
`ifdef LOADER_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            iov_q   <= iov_d;
            iod_q   <= iod_d;
            wc_q    <= wc_d;
`ifdef LOADER_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign io_valid   = iov_q;
    assign io_data    = iod_q;
    assign word_count = wc_q;

endmodule
